fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ requesters share one sync FIFO write port, bursts capped at BURST_MAX beats.
// Define FIFO_ARB_STATS_EN to add stats_clr / grant_cnt per-requester grant counters.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic                      fifo_full,
    output logic [1:0]                grant_id,
    output logic                      busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [N_REQ*16-1:0]       grant_cnt
`endif
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [1:0]  last_winner_q, last_winner_d;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        found;
    logic [3:0]  beat_next;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] grant_cnt_q [N_REQ];
    logic [15:0] grant_cnt_d [N_REQ];
`endif

    assign busy     = (state_q == BURST);
    assign grant_id = grant_id_q;

    // Datapath is gated by rst so no beat is accepted while the block is being reset.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (state_q == BURST && !rst) begin
            req_ready[grant_id_q] = ~fifo_full;
            fifo_wr_en            = req_valid[grant_id_q] & ~fifo_full;
            fifo_din              = req_data[grant_id_q*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = 2'((int'(last_winner_q) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        beat_cnt_d    = beat_cnt_q;
        last_winner_d = last_winner_q;
        beat_next     = beat_cnt_q + 4'd1;
        case (state_q)
            IDLE: begin
                if (found && !fifo_full) begin
                    state_d    = BURST;
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (!fifo_full) begin
                    if (!req_valid[grant_id_q]) begin
                        state_d       = IDLE;
                        last_winner_d = grant_id_q;
                    end else begin
                        beat_cnt_d = beat_next;
                        if (req_last[grant_id_q] || beat_next == 4'(BURST_MAX)) begin
                            state_d       = IDLE;
                            last_winner_d = grant_id_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    // Clear beats a same-cycle grant; counters stick at all-ones.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (stats_clr) begin
            for (int i = 0; i < N_REQ; i++) grant_cnt_d[i] = '0;
        end else if (state_q == IDLE && found && !fifo_full) begin
            if (grant_cnt_q[winner] != 16'hFFFF) grant_cnt_d[winner] = grant_cnt_q[winner] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) grant_cnt[i*16 +: 16] = grant_cnt_q[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            beat_cnt_q    <= '0;
            last_winner_q <= 2'(N_REQ - 1);
`ifdef FIFO_ARB_STATS_EN
            for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            beat_cnt_q    <= beat_cnt_d;
            last_winner_q <= last_winner_d;
`ifdef FIFO_ARB_STATS_EN
            grant_cnt_q   <= grant_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level model predicts per-cycle outputs and FIFO beats.
module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef FIFO_ARB_STATS_EN
    logic        stats_clr;
    logic [63:0] grant_cnt;
`endif

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [1:0]  grant;
        logic [3:0]  ready;
        logic        wr;
        logic [7:0]  din;
        logic [63:0] cnt;
    } status_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    status_t status_q[$];
    beat_t   beat_q[$];
    int      checks   = 0;
    int      failures = 0;

    // Model state: owner = -1 means no burst in progress.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = N_REQ - 1;
    int m_cnt[N_REQ];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts this cycle's outputs and advances to the next state.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                 input logic f, input logic r, input logic clr, output bit xfer);
        status_t s;
        beat_t   b;
        int      o;
        int      w;
        bit      hit;
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        fifo_full = f;
        rst       = r;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = clr;
`endif
        xfer    = 1'b0;
        s.busy  = (m_owner >= 0);
        s.grant = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        s.ready = '0;
        s.wr    = 1'b0;
        s.din   = '0;
        for (int i = 0; i < N_REQ; i++) s.cnt[i*16 +: 16] = 16'(m_cnt[i]);
        if (r) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = N_REQ - 1;
            for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        end else begin
            if (m_owner < 0) begin
                if (v != 4'd0 && !f) begin
                    hit = 1'b0;
                    w   = 0;
                    for (int i = 1; i <= N_REQ; i++) begin
                        if (!hit && v[(m_last + i) % N_REQ]) begin
                            w   = (m_last + i) % N_REQ;
                            hit = 1'b1;
                        end
                    end
                    m_owner = w;
                    m_beats = 0;
                    if (m_cnt[w] < 65535) m_cnt[w]++;
                end
            end else begin
                o       = m_owner;
                s.din   = d[o*8 +: 8];
                s.ready = f ? 4'd0 : (4'd1 << o);
                if (!f) begin
                    if (!v[o]) begin
                        m_last  = o;
                        m_owner = -1;
                    end else begin
                        s.wr   = 1'b1;
                        xfer   = 1'b1;
                        b.id   = 2'(o);
                        b.data = d[o*8 +: 8];
                        beat_q.push_back(b);
                        m_beats++;
                        if (l[o] || m_beats == BURST_MAX) begin
                            m_last  = o;
                            m_owner = -1;
                        end
                    end
                end
            end
            if (clr) for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        end
        status_q.push_back(s);
    endtask

    // Monitor: compares DUT outputs mid-cycle against whatever the stimulus side queued.
    always @(negedge clk) begin
        status_t s;
        beat_t   b;
        if (status_q.size() > 0) begin
            s = status_q.pop_front();
            checkOutput("busy", 64'(busy), 64'(s.busy));
            checkOutput("req_ready", 64'(req_ready), 64'(s.ready));
            checkOutput("fifo_wr_en", 64'(fifo_wr_en), 64'(s.wr));
            checkOutput("fifo_din", 64'(fifo_din), 64'(s.din));
            if (s.busy) checkOutput("grant_id", 64'(grant_id), 64'(s.grant));
`ifdef FIFO_ARB_STATS_EN
            checkOutput("grant_cnt", grant_cnt, s.cnt);
`endif
            if (fifo_wr_en === 1'b1) begin
                if (beat_q.size() == 0) begin
                    checkOutput("beat_q_empty_on_write", 64'(beat_q.size()), 64'd1);
                end else begin
                    b = beat_q.pop_front();
                    checkOutput("beat_data", 64'(fifo_din), 64'(b.data));
                    checkOutput("beat_owner", 64'(grant_id), 64'(b.id));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          x;
        int          k;
        int          hold;
        logic [31:0] d;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;

        $display("[TB] reset with all requesters valid");
        repeat (2) applyStimulus(4'hF, 32'h44332211, 4'hF, 1'b0, 1'b1, 1'b0, x);

        $display("[TB] round robin, single-beat bursts");
        for (int i = 0; i < 10; i++) applyStimulus(4'hF, $urandom, 4'hF, 1'b0, 1'b0, 1'b0, x);
        repeat (2) applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, x);

        $display("[TB] burst cap on requester 2");
        k = 0;
        for (int i = 0; i < 14; i++) begin
            d = 32'(8'hA0 + 8'(k)) << 16;
            applyStimulus(4'b0100, d, 4'h0, 1'b0, 1'b0, 1'b0, x);
            if (x) k++;
        end
        repeat (2) applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, x);

        $display("[TB] backpressure inside a 4-beat burst");
        k = 0;
        hold = 0;
        for (int i = 0; i < 12 && k < 4; i++) begin
            logic f;
            f = (k == 2 && hold < 3);
            if (f) hold++;
            applyStimulus(4'b0001, 32'(8'h10 + 8'(k)), {3'b0, k == 3}, f, 1'b0, 1'b0, x);
            if (x) k++;
        end
        repeat (2) applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, x);

        $display("[TB] requester release after one beat");
        k = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((k == 0) ? 4'b0010 : 4'b0000, 32'h5500 + 32'(k << 8), 4'h0, 1'b0, 1'b0, 1'b0, x);
            if (x) k++;
        end

        $display("[TB] reset in the middle of a burst");
        for (int i = 0; i < 3; i++) applyStimulus(4'b1000, $urandom, 4'h0, 1'b0, 1'b0, 1'b0, x);
        applyStimulus(4'hF, $urandom, 4'h0, 1'b0, 1'b1, 1'b0, x);
        for (int i = 0; i < 3; i++) applyStimulus(4'hF, $urandom, 4'hF, 1'b0, 1'b0, 1'b0, x);
        repeat (2) applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, x);

        $display("[TB] five grants to requester 3, then counter clear");
        for (int i = 0; i < 10; i++) applyStimulus(4'b1000, $urandom, 4'b1000, 1'b0, 1'b0, 1'b0, x);
        applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, x);
        applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, x);
        repeat (2) applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, x);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] v;
            logic [3:0] l;
            v = 4'($urandom) | 4'($urandom);
            l = 4'($urandom) & 4'($urandom);
            applyStimulus(v, $urandom, l, ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0), x);
        end
        repeat (3) applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, x);

        @(negedge clk);
        #1;
        checkOutput("beat_q_drained", 64'(beat_q.size()), 64'd0);
        checkOutput("status_q_drained", 64'(status_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
